// File: rtl/mem_arb_pkg.sv
// Shared FSM state encoding and requester identifiers for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between the fetch and data requesters.
// Define MEM_ARB_RR_EN for round-robin contention; otherwise data always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_owner,
    output logic grant_valid_c,
    output logic grant_owner_c
);

`ifndef MEM_ARB_RR_EN
    // Fixed priority never looks at the previous grant.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        grant_valid_c = i_req | d_req;
        grant_owner_c = OWN_I;
        if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            grant_owner_c = ~last_owner;
`else
            grant_owner_c = OWN_D;
`endif
        end else if (d_req) begin
            grant_owner_c = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) single-port memory arbiter with fixed 3-cycle occupancy.
// Build option MEM_ARB_RR_EN selects round-robin contention (see mem_arb_pick).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              owner
);

    state_t state;
    logic   we_q;
    logic   i_rd_en;
    logic   d_rd_en;
    logic   grant_valid;
    logic   grant_owner;

    mem_arb_pick u_pick (
        .i_req         (i_req),
        .d_req         (d_req),
        .last_owner    (owner),
        .grant_valid_c (grant_valid),
        .grant_owner_c (grant_owner)
    );

    // mem_address and mem_data_in double as the registered request address and write data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWN_I;
            we_q        <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            mem_write   <= 1'b0;
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
            i_rd_en     <= 1'b0;
            d_rd_en     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state       <= ACCESS;
                        busy        <= 1'b1;
                        owner       <= grant_owner;
                        we_q        <= (grant_owner == OWN_D) && d_we;
                        mem_address <= (grant_owner == OWN_D) ? d_addr : i_addr;
                        mem_write   <= (grant_owner == OWN_D) && d_we;
                        mem_data_in <= ((grant_owner == OWN_D) && d_we) ? d_wdata : '0;
                    end
                end
                ACCESS: begin
                    state       <= RESP;
                    mem_write   <= 1'b0;
                    mem_data_in <= '0;
                    i_ack       <= (owner == OWN_I);
                    d_ack       <= (owner == OWN_D);
                    i_rd_en     <= (owner == OWN_I);
                    d_rd_en     <= (owner == OWN_D) && !we_q;
                end
                RESP: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    we_q        <= 1'b0;
                    mem_address <= '0;
                    i_ack       <= 1'b0;
                    d_ack       <= 1'b0;
                    i_rd_en     <= 1'b0;
                    d_rd_en     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory read data arrives during RESP, so the return path is a gated pass-through.
    assign i_rdata = i_rd_en ? mem_data_out : '0;
    assign d_rdata = d_rd_en ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-schedule model of the arbiter.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic        v;
        logic        resp;
        logic        own;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, mem_write, busy, owner;
    logic [31:0] i_rdata, d_rdata, mem_address, mem_data_in;
    logic [31:0] mem_data_out;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    bit          mem_init = 1'b0;

    exp_t        ring [4];
    logic        m_owner;
    int          next_free;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        last_i_ack, last_d_ack;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_ack        (i_ack),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out),
        .busy         (busy),
        .owner        (owner)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int k);
        return (k == 4) ? 32'h0050_0093 : (32'hA5A5_0000 | 32'(k));
    endfunction

    // Synchronous memory: read data valid the cycle after the address.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
            mem_init <= 1'b1;
        end else if (mem_write) begin
            mem[mem_address[9:2]] <= mem_data_in;
        end
        mem_data_out <= mem[mem_address[9:2]];
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: each grant books an access cycle and a response cycle in the schedule ring.
    task model_check();
        exp_t        e;
        logic        own, we;
        logic [31:0] ad, wd;
        logic [31:0] x_addr, x_wd, x_ir, x_dr;
        logic        x_w, x_ia, x_da, x_busy, x_own;
        e = ring[cyc % 4];
        ring[cyc % 4] = '0;
        if (rst) begin
            for (int k = 0; k < 4; k++) ring[k] = '0;
            e = '0;
            m_owner = 1'b0;
            next_free = 0;
        end
        x_addr = '0; x_wd = '0; x_ir = '0; x_dr = '0;
        x_w = 1'b0; x_ia = 1'b0; x_da = 1'b0; x_busy = 1'b0;
        x_own = m_owner;
        if (e.v) begin
            x_busy = 1'b1;
            x_addr = e.addr;
            if (!e.resp) begin
                x_w = e.we;
                if (e.we) begin
                    x_wd = e.wdata;
                    ref_mem[e.addr[9:2]] = e.wdata;
                end
            end else begin
                if (e.own) x_da = 1'b1;
                else       x_ia = 1'b1;
                if (!e.we) begin
                    if (e.own) x_dr = ref_mem[e.addr[9:2]];
                    else       x_ir = ref_mem[e.addr[9:2]];
                end
            end
        end
        chk("bus", 160'({mem_address, mem_data_in, mem_write, i_ack, d_ack, i_rdata, d_rdata, busy, owner}),
                   160'({x_addr, x_wd, x_w, x_ia, x_da, x_ir, x_dr, x_busy, x_own}));
        if (!rst && cyc >= next_free && (i_req || d_req)) begin
            if (i_req && d_req) own = RR ? ~m_owner : 1'b1;
            else                own = d_req;
            we = own & d_we;
            ad = own ? d_addr : i_addr;
            wd = we ? d_wdata : '0;
            ring[(cyc + 1) % 4] = {1'b1, 1'b0, own, we, ad, wd};
            ring[(cyc + 2) % 4] = {1'b1, 1'b1, own, we, ad, wd};
            m_owner = own;
            next_free = cyc + 3;
        end
    endtask

    // Check the current cycle at the falling edge, then advance to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        model_check();
        last_i_ack = i_ack;
        last_d_ack = d_ack;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 255)) << 2;
    endfunction

    initial begin
        logic [3:0]  dseq;
        int          icount;
        int          bad;
        bit          i_pend, d_pend;
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
        for (int k = 0; k < 4; k++) ring[k] = '0;
        m_owner = 1'b0; next_free = 0;
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        #1;
        chk("reset_busy", 160'(busy), 160'(0));
        chk("reset_owner", 160'(owner), 160'(0));
        chk("reset_mem_write", 160'(mem_write), 160'(0));
        step(); step();
        rst = 1'b0;
        step();

        // Lone fetch of 0x10.
        i_req = 1'b1; i_addr = 32'h10;
        step();
        chk("fetch_mem_address", 160'(mem_address), 160'(32'h10));
        step();
        chk("fetch_ack", 160'({i_ack, d_ack}), 160'(2'b10));
        chk("fetch_data", 160'(i_rdata), 160'(32'h0050_0093));
        step();
        i_req = 1'b0;
        step();

        // Data write to 0x40 then fetch it back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        step();
        chk("write_strobe", 160'({mem_write, mem_data_in}), 160'({1'b1, 32'hDEAD_BEEF}));
        step();
        chk("write_ack", 160'({mem_write, d_ack, d_rdata}), 160'({1'b0, 1'b1, 32'h0}));
        step();
        d_req = 1'b0; d_we = 1'b0;
        i_req = 1'b1; i_addr = 32'h40;
        step(); step();
        chk("readback", 160'({i_ack, i_rdata}), 160'({1'b1, 32'hDEAD_BEEF}));
        step();
        i_req = 1'b0;
        step();

        // Sustained contention for 12 cycles.
        i_req = 1'b1; i_addr = 32'hC; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
        dseq = '0; icount = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k % 3 == 2) dseq[k / 3] = d_ack;
            icount += int'(i_ack);
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("contention_pattern", 160'(dseq), 160'(RR ? 4'b0101 : 4'b1111));
        chk("contention_fetch_acks", 160'(icount), 160'(RR ? 2 : 0));
        step();

        // Reset during the access cycle of a write to 0x80.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234_5678;
        step();
        chk("abort_pre_write", 160'(mem_write), 160'(1));
        rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
        #1;
        chk("abort_write_drop", 160'(mem_write), 160'(0));
        chk("abort_busy", 160'(busy), 160'(0));
        step(); step();
        rst = 1'b0;
        step(); step();
        chk("abort_mem_kept", 160'(mem[32]), 160'(32'hA5A5_0020));
        chk("abort_idle", 160'({busy, d_ack, i_ack}), 160'(0));

        // Back-to-back fetches with req held across each ack.
        i_req = 1'b1; i_addr = 32'h0;
        for (int j = 0; j < 3; j++) begin
            step(); step();
            chk("stream_fetch", 160'({i_ack, i_rdata}), 160'({1'b1, 32'hA5A5_0000 | 32'(j)}));
            step();
            if (j < 2) i_addr = 32'((j + 1) * 4);
            else       i_req = 1'b0;
        end
        step();

        // Randomized traffic with one mid-run reset.
        i_pend = 1'b0; d_pend = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (t == 200) begin
                rst = 1'b1; i_pend = 1'b0; d_pend = 1'b0; i_req = 1'b0; d_req = 1'b0;
                step(); step();
                rst = 1'b0;
            end
            if (i_pend && last_i_ack) i_pend = 1'b0;
            if (d_pend && last_d_ack) d_pend = 1'b0;
            if (!i_pend && $urandom_range(0, 3) == 0) begin
                i_pend = 1'b1;
                i_addr = rand_addr();
            end
            if (!d_pend && $urandom_range(0, 3) == 0) begin
                d_pend = 1'b1;
                d_we = 1'($urandom_range(0, 1));
                d_addr = rand_addr();
                d_wdata = $urandom();
            end
            i_req = i_pend;
            d_req = d_pend;
            step();
        end
        i_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 4; k++) step();

        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) bad++;
        chk("mem_final_words_differing", 160'(bad), 160'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the address width of both requesters and the memory.
REQ-002 SHALL have parameter DATA_W, default 32, the data width of both requesters and the memory.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports i_req (in, 1, fetch request), i_addr (in, ADDR_W, fetch address), i_ack (out, 1, fetch done), i_rdata (out, DATA_W, fetch data).
REQ-006 SHALL have ports d_req (in, 1, data request), d_we (in, 1, write when 1), d_addr (in, ADDR_W), d_wdata (in, DATA_W), d_ack (out, 1), d_rdata (out, DATA_W).
REQ-007 SHALL have ports mem_address (out, ADDR_W), mem_data_in (out, DATA_W, write data to memory), mem_write (out, 1), mem_data_out (in, DATA_W, memory read data, valid one cycle after address).
REQ-008 SHALL have ports busy (out, 1, state not IDLE) and owner (out, 1, 0=fetch, 1=data; current or last grant).

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, RESP; transitions IDLE->ACCESS on any req, ACCESS->RESP always, RESP->IDLE always.
REQ-010 SHALL register the granted requester's address, we and wdata on the IDLE->ACCESS edge; requests in other states are ignored.
REQ-011 SHALL drive mem_address from the registered address in ACCESS and RESP, 0 in IDLE.
REQ-012 SHALL assert mem_write for exactly the ACCESS cycle, only for a granted data write; mem_data_in = registered wdata then, 0 otherwise.
REQ-013 SHALL pulse exactly one of i_ack/d_ack for one cycle in RESP, for the owner only.
REQ-014 SHALL drive the owner's rdata = mem_data_out during RESP, 0 otherwise and for the non-owner; write-ack rdata is 0.
REQ-015 SHALL give fixed 3-cycle occupancy: req sampled in cycle N, ack in cycle N+2, next grant earliest sampled in N+3.
REQ-016 SHALL require requesters to hold req and request fields stable until ack; req dropped before sampling is not serviced.
REQ-017 SHALL resolve simultaneous i_req and d_req in IDLE per REQ-022/023; the loser keeps req high and is granted next IDLE.
REQ-018 SHALL treat req still high in the cycle after its ack as a new request.

Reset
REQ-019 SHALL, while rst=1, force state IDLE, owner 0, registered fields 0, all outputs 0, regardless of clk.
REQ-020 SHALL abort any in-flight transaction on rst with no ack issued; mem_write drops immediately (asynchronously).
REQ-021 SHALL sample requests normally on the first rising edge after rst deasserts.

Configuration
REQ-022 SHALL, without macro MEM_ARB_RR_EN, use fixed priority: data wins every contention.
REQ-023 SHALL, with MEM_ARB_RR_EN defined, use round-robin: contention goes to the requester not granted last (owner); after reset the first contention goes to data.

Structure
REQ-024 SHALL place FSM state encoding (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10) and owner constants (OWN_I=0, OWN_D=1) in shared package mem_arb_pkg.
REQ-025 SHALL implement the grant choice in combinational sub-module mem_arb_pick (inputs i_req, d_req, last owner; output grant valid and owner).

Verification
REQ-026 SHALL cover: lone fetch, i_addr=0x10, memory word 0x00500093 -> mem_address=0x10 in N+1, i_ack and i_rdata=0x00500093 in N+2, d_ack never.
REQ-027 SHALL cover: data write d_addr=0x40, d_wdata=0xDEADBEEF -> mem_write=1 only in N+1, d_ack in N+2; subsequent fetch of 0x40 returns 0xDEADBEEF.
REQ-028 SHALL cover: i_req and d_req held high together for 12 cycles -> fixed build: data acked every 3 cycles, fetch never; RR build: D,I,D,I acks at N+2, N+5, N+8, N+11.
REQ-029 SHALL cover: rst pulsed during ACCESS of a write to 0x80 -> mem_write falls with rst, no ack, memory at 0x80 unchanged, busy=0.
REQ-030 SHALL cover: i_req held high across its ack with i_addr stepping 0x0,0x4,0x8 -> three acks 3 cycles apart with matching data.
